// File: rtl/pl_io_port_responder.sv
// Memory-mapped I/O responder: registered output ports, synchronized inputs, sticky change flags.
// Define IO_TIMER_EN to add a free-running 32-bit timer readable at offset 0xCC.
module pl_io_port_responder #(
    parameter int          IO_SEL_BIT  = 7,
    parameter logic [31:0] OUT_RST_VAL = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] out_port2,
    output logic [31:0] io_read_data,
    output logic        io_sel
);

    localparam logic [5:0] OFF_OUT0   = 6'h20;
    localparam logic [5:0] OFF_OUT1   = 6'h21;
    localparam logic [5:0] OFF_OUT2   = 6'h22;
    localparam logic [5:0] OFF_IN0    = 6'h30;
    localparam logic [5:0] OFF_IN1    = 6'h31;
    localparam logic [5:0] OFF_STATUS = 6'h32;
    localparam logic [5:0] OFF_TIMER  = 6'h33;

    logic [5:0]  word_off;
    logic        wr_en;
    logic        rd_en;
    logic        rd_status;
    logic [31:0] rd_mux;

    logic [31:0] p0_s1, p0_s2, p0_s3;
    logic [31:0] p1_s1, p1_s2, p1_s3;
    logic [1:0]  chg;
    logic [1:0]  status_q;

    logic        unused_addr;

    assign word_off    = addr[7:2];
    assign io_sel      = addr[IO_SEL_BIT];
    assign wr_en       = we & io_sel;
    assign rd_en       = re & io_sel;
    assign rd_status   = rd_en && (word_off == OFF_STATUS);
    assign chg         = {p1_s2 != p1_s3, p0_s2 != p0_s3};
    assign unused_addr = ^{addr[31:8], addr[1:0]};

`ifdef IO_TIMER_EN
    logic [31:0] timer_q;

    always_ff @(posedge clock) begin
        if (reset)
            timer_q <= 32'h0;
        else
            timer_q <= timer_q + 32'h1;
    end
`endif

    always_comb begin
        rd_mux = 32'h0;
        case (word_off)
            OFF_OUT0:   rd_mux = out_port0;
            OFF_OUT1:   rd_mux = out_port1;
            OFF_OUT2:   rd_mux = out_port2;
            OFF_IN0:    rd_mux = p0_s2;
            OFF_IN1:    rd_mux = p1_s2;
            OFF_STATUS: rd_mux = {30'h0, status_q};
`ifdef IO_TIMER_EN
            OFF_TIMER:  rd_mux = timer_q;
`else
            OFF_TIMER:  rd_mux = 32'h0;
`endif
            default:    rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_port0 <= OUT_RST_VAL;
            out_port1 <= OUT_RST_VAL;
            out_port2 <= OUT_RST_VAL;
        end else if (wr_en) begin
            if (word_off == OFF_OUT0) out_port0 <= datain;
            if (word_off == OFF_OUT1) out_port1 <= datain;
            if (word_off == OFF_OUT2) out_port2 <= datain;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            io_read_data <= 32'h0;
        else if (rd_en)
            io_read_data <= rd_mux;
    end

    // s3 lags s2 by one clock so s2 != s3 marks a fresh input change
    always_ff @(posedge clock) begin
        if (reset) begin
            p0_s1 <= 32'h0;
            p0_s2 <= 32'h0;
            p0_s3 <= 32'h0;
            p1_s1 <= 32'h0;
            p1_s2 <= 32'h0;
            p1_s3 <= 32'h0;
        end else begin
            p0_s1 <= in_port0;
            p0_s2 <= p0_s1;
            p0_s3 <= p0_s2;
            p1_s1 <= in_port1;
            p1_s2 <= p1_s1;
            p1_s3 <= p1_s2;
        end
    end

    // a change arriving with a STATUS read survives the clear
    always_ff @(posedge clock) begin
        if (reset)
            status_q <= 2'b00;
        else
            status_q <= (rd_status ? 2'b00 : status_q) | chg;
    end

endmodule

// File: tb/tb_pl_io_port_responder.sv
// Randomized self-checking bench for pl_io_port_responder.
// Reference model tracks port values, input sample history, flags and elapsed cycles.
module tb_pl_io_port_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        we;
    logic        re;
    logic [31:0] in_port0;
    logic [31:0] in_port1;
    logic [31:0] out_port0;
    logic [31:0] out_port1;
    logic [31:0] out_port2;
    logic [31:0] io_read_data;
    logic        io_sel;

    int checks   = 0;
    int failures = 0;

    pl_io_port_responder dut (
        .clock        (clock),
        .reset        (reset),
        .addr         (addr),
        .datain       (datain),
        .we           (we),
        .re           (re),
        .in_port0     (in_port0),
        .in_port1     (in_port1),
        .out_port0    (out_port0),
        .out_port1    (out_port1),
        .out_port2    (out_port2),
        .io_read_data (io_read_data),
        .io_sel       (io_sel)
    );

    always #5 clock = ~clock;

    // reference state
    logic [31:0] m_out [3];
    logic [31:0] m_rd;
    logic [1:0]  m_flags;
    logic [31:0] h0 [3];
    logic [31:0] h1 [3];
    logic [31:0] m_cycles;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [31:0] v;
        v = 32'h0;
        case (a & 8'hFC)
            8'h80: v = m_out[0];
            8'h84: v = m_out[1];
            8'h88: v = m_out[2];
            8'hC0: v = h0[1];
            8'hC4: v = h1[1];
            8'hC8: v = {30'h0, m_flags};
`ifdef IO_TIMER_EN
            8'hCC: v = m_cycles;
`endif
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // one clock: predict, advance, compare
    task automatic step();
        logic [7:0] a;
        logic       sel;
        logic [1:0] chg;
        a   = addr[7:0];
        sel = addr[7];
        check("io_sel", {31'h0, io_sel}, {31'h0, sel});
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_out[i] = 32'h0;
                h0[i]    = 32'h0;
                h1[i]    = 32'h0;
            end
            m_rd     = 32'h0;
            m_flags  = 2'b00;
            m_cycles = 32'h0;
        end else begin
            chg = {h1[1] != h1[2], h0[1] != h0[2]};
            if (re && sel) m_rd = model_read(a);
            if (re && sel && (a & 8'hFC) == 8'hC8)
                m_flags = chg;
            else
                m_flags = m_flags | chg;
            if (we && sel) begin
                case (a & 8'hFC)
                    8'h80: m_out[0] = datain;
                    8'h84: m_out[1] = datain;
                    8'h88: m_out[2] = datain;
                    default: ;
                endcase
            end
            h0[2] = h0[1]; h0[1] = h0[0]; h0[0] = in_port0;
            h1[2] = h1[1]; h1[1] = h1[0]; h1[0] = in_port1;
            m_cycles = m_cycles + 32'h1;
        end
        @(posedge clock);
        #1;
        check("out_port0", out_port0, m_out[0]);
        check("out_port1", out_port1, m_out[1]);
        check("out_port2", out_port2, m_out[2]);
        check("io_read_data", io_read_data, m_rd);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic r, input logic rst);
        addr   = a;
        datain = d;
        we     = w;
        re     = r;
        reset  = rst;
        step();
    endtask

    task automatic idle();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [31:0] t_first;
    logic [31:0] t_second;
    logic [31:0] ra;

    initial begin
        reset    = 1'b1;
        addr     = 32'h0;
        datain   = 32'h0;
        we       = 1'b0;
        re       = 1'b0;
        in_port0 = 32'h0;
        in_port1 = 32'h0;
        for (int i = 0; i < 3; i++) begin
            m_out[i] = 32'h0;
            h0[i]    = 32'h0;
            h1[i]    = 32'h0;
        end
        m_rd     = 32'h0;
        m_flags  = 2'b00;
        m_cycles = 32'h0;
        #2;

        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("rst_out0", out_port0, 32'h0);
        check("rst_rd", io_read_data, 32'h0);

        drive(32'h84, 32'hA5, 1'b1, 1'b0, 1'b0);
        check("wr_out1", out_port1, 32'hA5);
        check("wr_out0_kept", out_port0, 32'h0);
        check("wr_out2_kept", out_port2, 32'h0);
        drive(32'h84, 32'h0, 1'b0, 1'b1, 1'b0);
        check("rd_out1", io_read_data, 32'hA5);
        drive(32'hD0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("rd_unmapped", io_read_data, 32'h0);

        in_port0 = 32'h1234_5678;
        idle();
        drive(32'hC0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("in0_early", io_read_data, 32'h0);
        drive(32'hC0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("in0_ready", io_read_data, 32'h1234_5678);
        drive(32'hC8, 32'h0, 1'b0, 1'b1, 1'b0);
        check("status_set", io_read_data, 32'h1);
        drive(32'hC8, 32'h0, 1'b0, 1'b1, 1'b0);
        check("status_clr", io_read_data, 32'h0);

        in_port1 = 32'hCAFE_0001;
        idle();
        idle();
        drive(32'hC8, 32'h0, 1'b0, 1'b1, 1'b0);
        check("status_race_old", io_read_data, 32'h0);
        drive(32'hC8, 32'h0, 1'b0, 1'b1, 1'b0);
        check("status_set_wins", io_read_data, 32'h2);

        drive(32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        check("wr_nosel", out_port0, 32'h0);
        drive(32'h84, 32'h0, 1'b0, 1'b1, 1'b1);
        check("rst_abort_rd", io_read_data, 32'h0);

        for (int i = 0; i < 10; i++) idle();
        drive(32'hCC, 32'h0, 1'b0, 1'b1, 1'b0);
        t_first = io_read_data;
        for (int i = 0; i < 4; i++) idle();
        drive(32'hCC, 32'h0, 1'b0, 1'b1, 1'b0);
        t_second = io_read_data;
`ifdef IO_TIMER_EN
        check("timer_delta", t_second - t_first, 32'h5);
`else
        check("timer_absent", t_second | t_first, 32'h0);
`endif

        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 9))
                0: ra = 32'h80;
                1: ra = 32'h84;
                2: ra = 32'h88;
                3: ra = 32'hC0;
                4: ra = 32'hC4;
                5: ra = 32'hC8;
                6: ra = 32'hCC;
                7: ra = 32'hD0;
                default: ra = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = ra ^ 32'h80;
            ra = ra | ($urandom & 32'hFFFF_FF03);
            if ($urandom_range(0, 3) == 0) in_port0 = $urandom;
            if ($urandom_range(0, 3) == 0) in_port1 = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2: drive(ra, $urandom, 1'b1, 1'b0, 1'b0);
                3, 4, 5, 6: drive(ra, $urandom, 1'b0, 1'b1, 1'b0);
                7: drive(ra, $urandom, 1'b1, 1'b1, 1'b0);
                default: drive(ra, $urandom, 1'b0, 1'b0,
                               $urandom_range(0, 19) == 0);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
